imem_boot_loader: RTL and testbench

// Streams a program image into the MIPS instruction memory before the CPU runs, replacing
// the simulation-only $readmemh preload. Sits directly upstream of the instruction memory and
// CPU: accepts a byte stream, packs big-endian 32-bit words, writes them from address 0 upward,

---
 rtl/imem_boot_loader.sv | 130 +++++++++++++
 tb/tb_imem_boot_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream instruction-memory loader: LEN_HI, LEN_LO, 4*N big-endian data bytes, XOR checksum.
// Each word is written one cycle after its 4th byte; in_ready is high throughout a frame, and memory writes never stall the stream.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state, state_nx;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        hs;
  logic        last_word;
  logic [15:0] len_rx;
  logic        restart;

  assign hs        = in_valid & in_ready;
  assign len_rx    = {len[15:8], in_data};
  assign last_word = (byte_cnt == 2'd3) && (word_count == len - 16'd1);
  assign restart   = start && (state == IDLE || state == DONE || state == ERROR);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_run  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) state_nx = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (len_rx == 16'd0)             state_nx = CSUM;
          else if ({1'b0, len_rx} > CAP)   state_nx = ERROR;
          else                             state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && last_word) state_nx = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs) state_nx = (csum == in_data) ? DONE : ERROR;
      end
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      im_we <= 1'b0;
      if (restart) begin
        word_count <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
      end
      if (hs) begin
        case (state)
          LEN_HI: len[15:8] <= in_data;
          LEN_LO: len[7:0]  <= in_data;
          DATA: begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {word_buf[15:0], in_data};
            // Address is taken before the increment, so word k lands at address k.
            if (byte_cnt == 2'd3) begin
              im_we      <= 1'b1;
              im_addr    <= word_count[ADDR_W-1:0];
              im_wdata   <= {word_buf, in_data};
              word_count <= word_count + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares them, and the main thread checks end-of-frame status.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_we, cpu_run, busy, done, error;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  ea;
  logic [31:0] ed;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", im_addr, im_wdata);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        chk("write_addr", {24'd0, im_addr}, {24'd0, ea});
        chk("write_data", im_wdata, ed);
      end
    end
  end

  function automatic logic [7:0] xor_of(input logic [7:0] d[$]);
    logic [7:0] x = 8'h00;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered and left at a negedge; optional idle gaps may carry stray start pulses.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = ($urandom_range(0, 4) == 0);
        @(negedge clk);
      end
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] n, input logic [7:0] d[$], input logic [7:0] cs,
                           input bit gaps, input bit do_start);
    logic ok;
    if (do_start) pulse_start();
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    if (n > 16'd256) begin
      chk("len_error", {31'd0, error}, 32'd1);
      chk("len_no_ready", {31'd0, in_ready}, 32'd0);
      chk("len_word_count", {16'd0, word_count}, 32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(8'(i));
      exp_data.push_back({d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]});
      for (int j = 0; j < 4; j++) send_byte(d[4*i+j], gaps);
    end
    send_byte(cs, gaps);
    wait_idle();
    ok = (cs == xor_of(d));
    chk("done", {31'd0, done}, {31'd0, ok});
    chk("error", {31'd0, error}, {31'd0, !ok});
    chk("cpu_run", {31'd0, cpu_run}, {31'd0, ok});
    chk("word_count", {16'd0, word_count}, {16'd0, n});
    chk("pending_writes", exp_addr.size(), 0);
  endtask

  initial begin
    logic [7:0] t1[$];
    logic [7:0] empty[$];
    logic [7:0] d[$];
    logic [15:0] n;
    logic [7:0] cs;

    repeat (2) @(negedge clk);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_error", {30'd0, done, error}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // The eight data bytes below XOR to 0x05; the model decides pass/fail for each checksum.
    t1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h01};
    run_frame(16'd2, t1, 8'h05, 1'b0, 1'b1);
    run_frame(16'd2, t1, 8'h04, 1'b0, 1'b1);

    run_frame(16'h0101, empty, 8'h00, 1'b0, 1'b1);
    run_frame(16'h0000, empty, 8'h00, 1'b0, 1'b1);
    run_frame(16'h0000, empty, 8'h01, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      n = 16'($urandom_range(1, 8));
      d.delete();
      for (int i = 0; i < 4 * int'(n); i++) d.push_back(8'($urandom));
      cs = xor_of(d) ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      run_frame(n, d, cs, 1'b1, 1'b1);
    end

    d.delete();
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    run_frame(16'd3, d, xor_of(d), 1'b1, 1'b1);
    pulse_start();
    chk("restart_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("restart_word_count", {16'd0, word_count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    run_frame(16'd3, d, xor_of(d), 1'b1, 1'b0);

    // Reset in the middle of the second word of a 3-word frame.
    d.delete();
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    exp_addr.push_back(8'h00);
    exp_data.push_back({d[0], d[1], d[2], d[3]});
    for (int i = 0; i < 6; i++) send_byte(d[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_im_we", {31'd0, im_we}, 32'd0);
    chk("arst_word_count", {16'd0, word_count}, 32'd0);
    chk("arst_status", {29'd0, cpu_run, done, error}, 32'd0);
    chk("arst_writes", exp_addr.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(16'd3, d, xor_of(d), 1'b0, 1'b1);

    d.delete();
    for (int i = 0; i < 1024; i++) d.push_back(8'($urandom));
    run_frame(16'd256, d, xor_of(d), 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
